// File: rtl/xdatabus_resp.sv
// Databus responder: round-robin arbitration over N_PORTS requesters in front of a single-port word memory.
// Optional transaction counter port perf_cnt is enabled by defining XDATABUS_RESP_PERF_EN.
module xdatabus_resp #(
    parameter int unsigned N_PORTS    = 3,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            databus_valid,
    input  logic [N_PORTS*ADDR_W-1:0]     databus_addr,
    input  logic [N_PORTS*DATA_W-1:0]     databus_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0]   databus_wstrb,
    output logic [N_PORTS-1:0]            databus_ready,
    output logic [N_PORTS*DATA_W-1:0]     databus_rdata
`ifdef XDATABUS_RESP_PERF_EN
   ,output logic [31:0]                   perf_cnt
`endif
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(STRB_W);
    localparam int unsigned PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                    state_q;
    logic [PORT_W-1:0]         ptr_q, ptr_d;
    logic [PORT_W-1:0]         gnt_q, gnt_d;
    logic [MEM_ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic [N_PORTS-1:0]        ready_q;
    logic [N_PORTS*DATA_W-1:0] rdata_q;
    logic                      found_d;
    int unsigned               idx_d;
    logic [DATA_W-1:0]         rd_word;
    logic                      unused_addr;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Round-robin pick starting at ptr_q, plus capture of the winner's request fields.
    always_comb begin
        gnt_d   = '0;
        found_d = 1'b0;
        idx_d   = 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx_d = 32'(ptr_q) + i;
            if (idx_d >= N_PORTS) idx_d = idx_d - N_PORTS;
            if (!found_d && databus_valid[PORT_W'(idx_d)]) begin
                found_d = 1'b1;
                gnt_d   = PORT_W'(idx_d);
            end
        end
        ptr_d   = (gnt_d == PORT_W'(N_PORTS - 1)) ? '0 : gnt_d + PORT_W'(1);
        waddr_d = databus_addr[32'(gnt_d) * ADDR_W + OFF_W +: MEM_ADDR_W];
        wdata_d = databus_wdata[32'(gnt_d) * DATA_W +: DATA_W];
        wstrb_d = databus_wstrb[32'(gnt_d) * STRB_W +: STRB_W];
    end

    // Upper address bits alias and byte-offset bits are dropped by design.
    assign unused_addr = ^databus_addr;

    assign rd_word = (~|wstrb_q) ? mem_q[waddr_q] : '0;

    // Control FSM with registered ready/rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|databus_valid) begin
                        gnt_q   <= gnt_d;
                        ptr_q   <= ptr_d;
                        waddr_q <= waddr_d;
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready_q[gnt_q]                            <= 1'b1;
                    rdata_q[32'(gnt_q) * DATA_W +: DATA_W]    <= rd_word;
                    state_q                                   <= RESP;
                end
                RESP: begin
                    ready_q <= '0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-masked write; reset in the ACCESS cycle cancels it. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ACCESS) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
                if (wstrb_q[k]) mem_q[waddr_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
            end
        end
    end

    assign databus_ready = ready_q;
    assign databus_rdata = rdata_q;

`ifdef XDATABUS_RESP_PERF_EN
    logic [31:0] perf_q;

    // Completed-transaction counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (|ready_q && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_xdatabus_resp.sv
// Directed self-checking bench for xdatabus_resp (default parameters).
// Perf-counter checks are compiled in when XDATABUS_RESP_PERF_EN is defined.
module tb_xdatabus_resp;

    localparam int unsigned NP = 3;
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP-1:0]       valid;
    logic [NP*AW-1:0]    addr;
    logic [NP*DW-1:0]    wdata;
    logic [NP*SW-1:0]    wstrb;
    logic [NP-1:0]       ready;
    logic [NP*DW-1:0]    rdata;
`ifdef XDATABUS_RESP_PERF_EN
    logic [31:0]         perf_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    xdatabus_resp dut (
        .clk           (clk),
        .rst           (rst),
        .databus_valid (valid),
        .databus_addr  (addr),
        .databus_wdata (wdata),
        .databus_wstrb (wstrb),
        .databus_ready (ready),
        .databus_rdata (rdata)
`ifdef XDATABUS_RESP_PERF_EN
       ,.perf_cnt      (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on port p; reports latency in cycles from the grant cycle.
    task automatic do_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output logic [DW-1:0] rd);
        logic [NP*DW-1:0] oth;
        int lat;
        @(posedge clk); #1;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
        wstrb[p*SW +: SW] = s;
        valid[p]          = 1'b1;
        lat = -1;
        rd  = '0;
        oth = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready[p]) begin
                lat = c;
                rd  = rdata[p*DW +: DW];
                oth = rdata;
                oth[p*DW +: DW] = '0;
                check_val("other_ready", DW'(ready & ~(NP'(1) << p)), '0);
                break;
            end
        end
        check_val("latency", DW'(lat), DW'(2));
        check_val("other_rdata", DW'(|oth), '0);
        @(posedge clk); #1;
        valid[p] = 1'b0;
    endtask

    logic [DW-1:0] rd;
    logic [DW-1:0] pat_a5, pat_p, pat_q, pat_r;
    int            seen [NP];
    logic [DW-1:0] got  [NP];
    logic [NP-1:0] drop;
    int            rdy_cnt;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_p  = {4{64'h0123_4567_89AB_CDEF}};
        pat_q  = {8{32'h1357_9BDF}};
        pat_r  = {8{32'hCAFE_F00D}};
        rst   = 1'b1;
        valid = '0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_ready", DW'(ready), '0);
        check_val("reset_rdata", DW'(|rdata), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full write then readback on port 1.
        do_req(1, 32'h40, pat_a5, '1, rd);
        check_val("wr40_rdata_zero", rd, '0);
        do_req(1, 32'h40, '0, '0, rd);
        check_val("rd40", rd, pat_a5);

        // Single-byte strobe over a zeroed word.
        do_req(0, 32'h20, '0, '1, rd);
        do_req(0, 32'h20, '1, SW'(1), rd);
        do_req(0, 32'h20, '0, '0, rd);
        check_val("rd20_byte0", rd, DW'(8'hFF));

        // Reset pointer, then three simultaneous reads; memory survives reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        addr  = {32'h40, 32'h20, 32'h40};
        wstrb = '0;
        valid = '1;
        drop  = '0;
        for (int p = 0; p < NP; p++) begin
            seen[p] = -1;
            got[p]  = '0;
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (ready[p]) begin
                    seen[p] = c;
                    got[p]  = rdata[p*DW +: DW];
                    drop[p] = 1'b1;
                end
            end
            @(posedge clk); #1;
            valid = valid & ~drop;
            drop  = '0;
        end
        valid = '0;
        check_val("rr_cycle_p0", DW'(seen[0]), DW'(2));
        check_val("rr_cycle_p1", DW'(seen[1]), DW'(5));
        check_val("rr_cycle_p2", DW'(seen[2]), DW'(8));
        check_val("rr_data_p0", got[0], pat_a5);
        check_val("rr_data_p1", got[1], DW'(8'hFF));
        check_val("rr_data_p2", got[2], pat_a5);

        // Word address aliasing above MEM_ADDR_W.
        do_req(0, 32'h0, pat_p, '1, rd);
        do_req(2, 32'h8000, '0, '0, rd);
        check_val("alias_8000", rd, pat_p);
`ifdef XDATABUS_RESP_PERF_EN
        check_val("perf_5", DW'(perf_cnt), DW'(5));
`endif

        // Reset during ACCESS cancels the write and its ready pulse.
        do_req(2, 32'h60, pat_q, '1, rd);
        @(posedge clk); #1;
        addr[0 +: AW]  = 32'h60;
        wdata[0 +: DW] = pat_r;
        wstrb[0 +: SW] = '1;
        valid[0]       = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b1;
        valid[0] = 1'b0;
        rdy_cnt  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (|ready) rdy_cnt++;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        check_val("rst_no_ready", DW'(rdy_cnt), '0);
`ifdef XDATABUS_RESP_PERF_EN
        check_val("perf_rst", DW'(perf_cnt), '0);
`endif
        do_req(1, 32'h60, '0, '0, rd);
        check_val("rd60_kept", rd, pat_q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xdatabus_resp.md
XDATABUS_RESP -- requirements
Module: xdatabus_resp

Interface
REQ-001 SHALL have parameter N_PORTS, default 3, number of databus requester ports.
REQ-002 SHALL have parameter DATA_W, default 256, databus data width in bits (DATAPATH_W).
REQ-003 SHALL have parameter ADDR_W, default 32, databus byte address width (IO_ADDR_W).
REQ-004 SHALL have parameter MEM_ADDR_W, default 10, word-address width of the internal memory (2^MEM_ADDR_W words of DATA_W bits).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port databus_valid, input, N_PORTS, per-port request valid.
REQ-008 SHALL have port databus_addr, input, N_PORTS*ADDR_W, per-port byte address; port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port databus_wdata, input, N_PORTS*DATA_W, per-port write data.
REQ-010 SHALL have port databus_wstrb, input, N_PORTS*DATA_W/8, per-port byte enables; all zero = read.
REQ-011 SHALL have port databus_ready, output, N_PORTS, per-port one-cycle completion pulse.
REQ-012 SHALL have port databus_rdata, output, N_PORTS*DATA_W, per-port read data, valid only while that port's ready is high.

Function
REQ-013 SHALL act as the responder end of the databus: requester holds valid/addr/wdata/wstrb stable until its ready pulse.
REQ-014 SHALL implement a three-state FSM: IDLE, ACCESS, RESP; IDLE->ACCESS when any valid is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-015 SHALL, in IDLE, grant one port by round-robin: search from pointer ptr upward with wrap; register port index, word address, wdata, wstrb.
REQ-016 SHALL set ptr to (granted+1) mod N_PORTS on each grant; ptr is 0 after reset.
REQ-017 SHALL form the word address as addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher address bits ignored (aliasing), low byte-offset bits ignored.
REQ-018 SHALL, in ACCESS, perform the memory access: write byte k where registered wstrb[k]=1; if wstrb all zero, read the word.
REQ-019 SHALL, in RESP, drive databus_ready[granted]=1 for exactly one cycle, all other ready bits 0.
REQ-020 SHALL drive databus_rdata[granted] with the read word for reads and all zeros for writes during RESP; all other rdata slices zero at all times.
REQ-021 SHALL yield fixed latency: ready pulses 2 cycles after the IDLE cycle in which the request was granted; throughput one transaction per 3 cycles.
REQ-022 SHALL treat a valid still high in the IDLE cycle after its RESP as a new request.
REQ-023 SHALL not starve: with all ports continuously requesting, grants follow 0,1,2,0,1,2,...
REQ-024 SHALL ignore valid changes on non-granted ports outside IDLE; no request is dropped while held.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set state=IDLE, ptr=0, databus_ready=0, databus_rdata=0.
REQ-026 SHALL give rst priority over any pending write: rst high during ACCESS suppresses the memory write; rst during RESP suppresses the ready pulse.
REQ-027 SHALL not initialise memory contents on reset.

Configuration
REQ-028 SHALL, with macro XDATABUS_RESP_PERF_EN defined, add output port perf_cnt, 32 bits, counting completed transactions (one per ready pulse), saturating at 0xFFFFFFFF, cleared by rst.
REQ-029 SHALL, without XDATABUS_RESP_PERF_EN, have no perf_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: port 1 writes wdata=0xA5 repeated, wstrb all ones, addr 0x40; then port 1 reads 0x40 -> read ready 2 cycles after grant, rdata 0xA5 repeated.
REQ-031 SHALL cover: write with wstrb=0x1 of 0xFF to addr 0x20 over previous all-zero word -> readback byte0=0xFF, other bytes 0x00.
REQ-032 SHALL cover: ports 0,1,2 all assert reads in same cycle, held until ready -> ready order 0,1,2 at cycles t+2, t+5, t+8.
REQ-033 SHALL cover: MEM_ADDR_W=10, DATA_W=256, write addr 0x0 then read addr 0x8000 -> same word returned (alias).
REQ-034 SHALL cover: rst pulsed during ACCESS of a write to 0x60 -> no ready pulse, later read of 0x60 returns prior contents.
REQ-035 SHALL cover (PERF_EN): 5 completed transactions -> perf_cnt=5; rst -> perf_cnt=0.
